// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR / interrupt trap unit: CSR addresses,
// mstatus bit positions, interrupt bit placement and the trap FSM state type.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // External interrupt channel i lives at mip/mie bit IRQ_BIT_BASE + i.
    localparam int IRQ_BIT_BASE = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } trap_state_e;

    // Cause code reported in mcause (and used for vectoring) for channel chan.
    function automatic logic [4:0] irqCauseCode(input logic [3:0] chan);
        return 5'(IRQ_BIT_BASE) + {1'b0, chan};
    endfunction

endpackage

// File: rtl/irq_pending.sv
// One external interrupt channel: two-flop synchroniser followed by either a
// level-following or a sticky rising-edge pending bit.
module irq_pending #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic irq_i,
    input  logic clear_i,
    output logic pending_o
);

    logic sync1_q;
    logic sync2_q;
    logic pending_q;
    logic pending_d;

    // Bring the asynchronous line into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    // Edge mode latches the rise seen between the sync stages so it appears together with the synchronised level; a set beats a same-cycle clear.
    always_comb begin
        if (EDGE) begin
            pending_d = (sync1_q & ~sync2_q) | (pending_q & ~clear_i);
        end else begin
            pending_d = sync1_q;
        end
    end

    // Pending state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with external interrupt trap entry, MRET return and
// redirect generation for the pipeline front end.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_IRQ-1:0]    irq_i,
    input  logic [11:0]           csr_addr_r_i,
    output logic [DATA_WIDTH-1:0] csr_rdata_o,
    input  logic                  csr_we_i,
    input  logic [11:0]           csr_addr_w_i,
    input  logic [DATA_WIDTH-1:0] csr_wdata_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  mret_i,
    input  logic                  trap_ack_i,
    output logic                  trap_req_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o
);

    trap_state_e           state_q;
    logic [4:0]            cause_q;
    logic [NUM_IRQ-1:0]    mieEn_q;
    logic [DATA_WIDTH-1:0] mtvec_q;
    logic [DATA_WIDTH-1:0] mscratch_q;
    logic [DATA_WIDTH-1:0] mepc_q;
    logic [DATA_WIDTH-1:0] mcause_q;
    logic                  mstIe_q;
    logic                  mstPie_q;

    logic [NUM_IRQ-1:0]    pending;
    logic [NUM_IRQ-1:0]    takeable;
    logic [NUM_IRQ-1:0]    grant;
    logic [NUM_IRQ-1:0]    clearPend;
    logic [4:0]            causeCode;
    logic                  takeTrap;
    logic                  mretAct;
    logic [DATA_WIDTH-1:0] vecBase;
    logic [DATA_WIDTH-1:0] trapVector;
    logic [DATA_WIDTH-1:0] mstatusWord;
    logic [DATA_WIDTH-1:0] mieWord;
    logic [DATA_WIDTH-1:0] mipWord;

    logic weMstatus;
    logic weMie;
    logic weMtvec;
    logic weMscratch;
    logic weMepc;
    logic weMcause;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : gen_irq
        irq_pending #(
            .EDGE (IRQ_EDGE[i])
        ) u_irq_pending (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .irq_i     (irq_i[i]),
            .clear_i   (clearPend[i]),
            .pending_o (pending[i])
        );
    end

    assign takeable = pending & mieEn_q;

    // Lowest-index enabled pending channel wins; scanning downwards lets the last hit be the lowest.
    always_comb begin
        grant     = '0;
        causeCode = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (takeable[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                causeCode = irqCauseCode(4'(i));
            end
        end
    end

    // MRET has priority over a same-cycle interrupt, which is simply re-evaluated next cycle.
    assign mretAct   = (state_q == ST_IDLE) && mret_i;
    assign takeTrap  = (state_q == ST_IDLE) && mstIe_q && !mret_i && (|takeable);
    assign clearPend = takeTrap ? grant : '0;

    assign weMstatus  = csr_we_i && (csr_addr_w_i == CSR_MSTATUS);
    assign weMie      = csr_we_i && (csr_addr_w_i == CSR_MIE);
    assign weMtvec    = csr_we_i && (csr_addr_w_i == CSR_MTVEC);
    assign weMscratch = csr_we_i && (csr_addr_w_i == CSR_MSCRATCH);
    assign weMepc     = csr_we_i && (csr_addr_w_i == CSR_MEPC);
    assign weMcause   = csr_we_i && (csr_addr_w_i == CSR_MCAUSE);

    // Trap FSM: enter on a taken interrupt, remember its cause for vectoring, leave on acknowledge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (takeTrap) begin
                        state_q <= ST_TRAP;
                        cause_q <= causeCode;
                    end
                end
                ST_TRAP: begin
                    if (trap_ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // CSR storage; hardware trap-entry updates are applied last so they override software writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mieEn_q    <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mstIe_q    <= 1'b0;
            mstPie_q   <= 1'b0;
        end else begin
            if (weMie) begin
                mieEn_q <= csr_wdata_i[IRQ_BIT_BASE +: NUM_IRQ];
            end
            if (weMtvec) begin
                mtvec_q <= csr_wdata_i;
            end
            if (weMscratch) begin
                mscratch_q <= csr_wdata_i;
            end
            if (weMepc) begin
                mepc_q <= {csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
            end
            if (weMcause) begin
                mcause_q <= csr_wdata_i;
            end
            if (weMstatus) begin
                mstIe_q  <= csr_wdata_i[MSTATUS_MIE_BIT];
                mstPie_q <= csr_wdata_i[MSTATUS_MPIE_BIT];
            end
            if (mretAct) begin
                mstIe_q  <= mstPie_q;
                mstPie_q <= 1'b1;
            end
            if (takeTrap) begin
                mepc_q   <= pc_i;
                mcause_q <= {1'b1, {(DATA_WIDTH - 6){1'b0}}, causeCode};
                mstPie_q <= mstIe_q;
                mstIe_q  <= 1'b0;
            end
        end
    end

    // Assemble the sparse architectural views of mstatus, mie and mip.
    always_comb begin
        mstatusWord                                = '0;
        mstatusWord[MSTATUS_MIE_BIT]               = mstIe_q;
        mstatusWord[MSTATUS_MPIE_BIT]              = mstPie_q;
        mieWord                                    = '0;
        mieWord[IRQ_BIT_BASE +: NUM_IRQ]           = mieEn_q;
        mipWord                                    = '0;
        mipWord[IRQ_BIT_BASE +: NUM_IRQ]           = pending;
    end

    // Combinational CSR read port; unmapped addresses read as zero.
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_r_i)
            CSR_MSTATUS:  csr_rdata_o = mstatusWord;
            CSR_MIE:      csr_rdata_o = mieWord;
            CSR_MTVEC:    csr_rdata_o = mtvec_q;
            CSR_MSCRATCH: csr_rdata_o = mscratch_q;
            CSR_MEPC:     csr_rdata_o = mepc_q;
            CSR_MCAUSE:   csr_rdata_o = mcause_q;
            CSR_MIP:      csr_rdata_o = mipWord;
            default:      csr_rdata_o = '0;
        endcase
    end

    assign vecBase    = {mtvec_q[DATA_WIDTH-1:2], 2'b00};
    assign trapVector = (mtvec_q[1:0] == 2'b01) ? (vecBase + (DATA_WIDTH'(cause_q) << 2)) : vecBase;

    // Redirect target: trap vector while requesting, saved mepc during an accepted MRET, else zero.
    always_comb begin
        redirect_pc_o = '0;
        if (state_q == ST_TRAP) begin
            redirect_pc_o = trapVector;
        end else if (mret_i) begin
            redirect_pc_o = mepc_q;
        end
    end

    assign trap_req_o = (state_q == ST_TRAP);

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: a cycle-level behavioural model of the
// CSR/trap rules is compared every cycle, plus directed literal expectations.
module tb_csr_trap_unit;

    localparam logic [3:0]  EDGE_MASK = 4'b0100;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MSCR    = 12'h340;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  irq;
    logic [11:0] csrAddrR;
    logic [31:0] csrRdata;
    logic        csrWe;
    logic [11:0] csrAddrW;
    logic [31:0] csrWdata;
    logic [31:0] pc;
    logic        mret;
    logic        trapAck;
    logic        trapReq;
    logic [31:0] redirectPc;

    int checkCount = 0;
    int errorCount = 0;
    bit checking   = 1'b0;

    // Behavioural model state.
    logic [31:0] mMie, mMtvec, mMscratch, mMepc, mMcause;
    logic        mStIe, mStPie, mInTrap;
    int          mTrapCause;
    logic [3:0]  mEdgePend;
    logic [3:0]  irqPipe[$];

    csr_trap_unit #(
        .DATA_WIDTH (32),
        .NUM_IRQ    (4),
        .IRQ_EDGE   (EDGE_MASK)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .irq_i         (irq),
        .csr_addr_r_i  (csrAddrR),
        .csr_rdata_o   (csrRdata),
        .csr_we_i      (csrWe),
        .csr_addr_w_i  (csrAddrW),
        .csr_wdata_i   (csrWdata),
        .pc_i          (pc),
        .mret_i        (mret),
        .trap_ack_i    (trapAck),
        .trap_req_o    (trapReq),
        .redirect_pc_o (redirectPc)
    );

    always #5 clk = ~clk;

    // Pending view: level channels follow the two-cycle-delayed line, edge channels are sticky.
    function automatic logic [3:0] modelPending();
        return (irqPipe[0] & ~EDGE_MASK) | (mEdgePend & EDGE_MASK);
    endfunction

    function automatic logic [31:0] modelVector();
        logic [31:0] base;
        base = mMtvec & 32'hFFFF_FFFC;
        if (mMtvec[1:0] == 2'b01) return base + 32'(4 * mTrapCause);
        return base;
    endfunction

    function automatic logic [31:0] readModel(input logic [11:0] a);
        case (a)
            A_MSTATUS: return (32'(mStIe) << 3) | (32'(mStPie) << 7);
            A_MIE:     return mMie;
            A_MTVEC:   return mMtvec;
            A_MSCR:    return mMscratch;
            A_MEPC:    return mMepc;
            A_MCAUSE:  return mMcause;
            A_MIP:     return 32'(modelPending()) << 16;
            default:   return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mMie = 0; mMtvec = 0; mMscratch = 0; mMepc = 0; mMcause = 0;
        mStIe = 0; mStPie = 0; mInTrap = 0; mTrapCause = 0; mEdgePend = 0;
        irqPipe = '{4'b0, 4'b0};
    endtask

    task automatic modelStep();
        logic [3:0] takeable, oldVis, newVis, clr;
        logic       oldIe, oldPie, take;
        int         k;
        takeable = modelPending() & mMie[19:16];
        k = -1;
        for (int i = 0; i < 4; i++) if (takeable[i] && k < 0) k = i;
        take   = !mInTrap && mStIe && !mret && (k >= 0);
        oldIe  = mStIe;
        oldPie = mStPie;
        if (csrWe) begin
            case (csrAddrW)
                A_MSTATUS: begin mStIe = csrWdata[3]; mStPie = csrWdata[7]; end
                A_MIE:     mMie = csrWdata & 32'h000F_0000;
                A_MTVEC:   mMtvec = csrWdata;
                A_MSCR:    mMscratch = csrWdata;
                A_MEPC:    mMepc = csrWdata & 32'hFFFF_FFFC;
                A_MCAUSE:  mMcause = csrWdata;
                default: ;
            endcase
        end
        if (mret && !mInTrap) begin
            mStIe  = oldPie;
            mStPie = 1'b1;
        end
        clr = 4'b0;
        if (take) begin
            mMepc      = pc;
            mMcause    = 32'h8000_0000 | 32'(16 + k);
            mStPie     = oldIe;
            mStIe      = 1'b0;
            mTrapCause = 16 + k;
            mInTrap    = 1'b1;
            clr        = 4'(1 << k);
        end else if (mInTrap && trapAck) begin
            mInTrap = 1'b0;
        end
        oldVis = irqPipe[0];
        void'(irqPipe.pop_front());
        irqPipe.push_back(irq);
        newVis = irqPipe[0];
        mEdgePend = ((newVis & ~oldVis) | (mEdgePend & ~clr)) & EDGE_MASK;
    endtask

    // Advance the model on every clock edge, clearing it as soon as reset asserts.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) modelReset();
        else       modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Every cycle, compare all DUT outputs against the model well away from the clock edges.
    always @(negedge clk) begin
        #2;
        if (checking) begin
            checkOutput("cyc_trap_req", 32'(trapReq), 32'(mInTrap));
            checkOutput("cyc_redirect", redirectPc,
                        mInTrap ? modelVector() : (mret ? mMepc : 32'h0));
            checkOutput("cyc_rdata", csrRdata, readModel(csrAddrR));
        end
    end

    task automatic applyStimulus(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                                 input logic mr, input logic ack);
        @(negedge clk);
        csrWe = we; csrAddrW = wa; csrWdata = wd; mret = mr; trapAck = ack;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic writeCsr(input logic [11:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic peek(input string name, input logic [11:0] a, input logic [31:0] expected);
        idle();
        csrAddrR = a;
        #1;
        checkOutput(name, csrRdata, expected);
    endtask

    initial begin
        logic [11:0] addrList[7];
        addrList = '{A_MSTATUS, A_MIE, A_MTVEC, A_MSCR, A_MEPC, A_MCAUSE, A_MIP};
        rstN = 1'b1; irq = 4'b0; csrAddrR = 12'h0; csrWe = 1'b0; csrAddrW = 12'h0;
        csrWdata = 32'h0; pc = 32'h0; mret = 1'b0; trapAck = 1'b0;
        #1 rstN = 1'b0;
        #1 checking = 1'b1;
        checkOutput("reset_trap_req", 32'(trapReq), 32'h0);
        checkOutput("reset_redirect", redirectPc, 32'h0);
        idle(); idle();
        rstN = 1'b1;
        peek("reset_mstatus", A_MSTATUS, 32'h0);

        // Basic level interrupt on channel 0, three-cycle latency.
        $display("[TB] scenario: level interrupt latency");
        writeCsr(A_MTVEC, 32'h0000_0100);
        writeCsr(A_MIE, 32'h0001_0000);
        writeCsr(A_MSTATUS, 32'h0000_0008);
        pc = 32'h2000_0104;
        idle(); irq = 4'b0001;
        idle(); idle();
        #1 checkOutput("s1_no_trap_c2", 32'(trapReq), 32'h0);
        idle();
        #1 checkOutput("s1_trap_c3", 32'(trapReq), 32'h1);
        checkOutput("s1_vector", redirectPc, 32'h0000_0100);
        peek("s1_mcause", A_MCAUSE, 32'h8000_0010);
        peek("s1_mepc", A_MEPC, 32'h2000_0104);
        peek("s1_mstatus", A_MSTATUS, 32'h0000_0080);
        applyStimulus(1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
        #1 checkOutput("s1_mret_in_trap", redirectPc, 32'h0000_0100);
        irq = 4'b0;
        applyStimulus(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        idle();
        #1 checkOutput("s1_acked", 32'(trapReq), 32'h0);

        // MRET colliding with a takeable interrupt.
        $display("[TB] scenario: mret versus interrupt");
        idle(); irq = 4'b0001;
        idle(); idle(); idle();
        pc = 32'h3000_0200;
        writeCsr(A_MSTATUS, 32'h0000_0088);
        applyStimulus(1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
        #1 checkOutput("s3_mret_redirect", redirectPc, 32'h2000_0104);
        checkOutput("s3_no_trap_on_mret", 32'(trapReq), 32'h0);
        idle();
        #1 checkOutput("s3_no_trap_yet", 32'(trapReq), 32'h0);
        idle();
        #1 checkOutput("s3_trap_after", 32'(trapReq), 32'h1);
        peek("s3_mepc", A_MEPC, 32'h3000_0200);
        irq = 4'b0;
        applyStimulus(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        idle(); idle(); idle();

        // Priority and vectored mode, with an mepc write lost to trap entry.
        $display("[TB] scenario: priority and vectored mode");
        writeCsr(A_MTVEC, 32'h0000_1001);
        writeCsr(A_MIE, 32'h000A_0000);
        idle(); irq = 4'b1010;
        idle(); idle(); idle();
        writeCsr(A_MSTATUS, 32'h0000_0008);
        pc = 32'h4000_0010;
        writeCsr(A_MEPC, 32'hDEAD_BEEC);
        idle();
        #1 checkOutput("s2_trap", 32'(trapReq), 32'h1);
        checkOutput("s2_vector", redirectPc, 32'h0000_1044);
        peek("s2_mepc_hw_wins", A_MEPC, 32'h4000_0010);
        peek("s2_mcause", A_MCAUSE, 32'h8000_0011);
        irq = 4'b0;
        applyStimulus(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        idle(); idle(); idle();

        // Edge channel 2: sticky pending, cleared on trap; mtvec mode 2 acts as direct.
        $display("[TB] scenario: edge channel");
        writeCsr(A_MIE, 32'h0004_0000);
        writeCsr(A_MTVEC, 32'h0000_0202);
        idle(); irq = 4'b0100;
        idle(); irq = 4'b0;
        idle(); idle(); idle(); idle();
        peek("s4_mip_sticky", A_MIP, 32'h0004_0000);
        writeCsr(A_MSTATUS, 32'h0000_0008);
        writeCsr(A_MSCR, 32'h5A5A_5A5A);
        idle();
        #1 checkOutput("s4_trap", 32'(trapReq), 32'h1);
        checkOutput("s4_vector_mode2", redirectPc, 32'h0000_0200);
        peek("s4_mip_cleared", A_MIP, 32'h0);
        peek("s4_mscratch_completes", A_MSCR, 32'h5A5A_5A5A);
        peek("s4_mcause", A_MCAUSE, 32'h8000_0012);
        applyStimulus(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        idle();

        // Register masking and unmapped addresses.
        $display("[TB] scenario: csr masking");
        writeCsr(A_MEPC, 32'h0000_1237);
        peek("mepc_low_bits", A_MEPC, 32'h0000_1234);
        writeCsr(12'h7C0, 32'h1234_5678);
        peek("unmapped_read", 12'h7C0, 32'h0);
        writeCsr(A_MIP, 32'hFFFF_FFFF);
        peek("mip_read_only", A_MIP, 32'h0);
        writeCsr(A_MIE, 32'hFFFF_FFFF);
        peek("mie_mask", A_MIE, 32'h000F_0000);
        writeCsr(A_MSTATUS, 32'hFFFF_FFFF);
        peek("mstatus_mask", A_MSTATUS, 32'h0000_0088);
        writeCsr(A_MSTATUS, 32'h0);

        // Reset while a trap is outstanding.
        $display("[TB] scenario: reset during trap");
        writeCsr(A_MIE, 32'h0001_0000);
        writeCsr(A_MTVEC, 32'h0000_0100);
        writeCsr(A_MSTATUS, 32'h0000_0008);
        idle(); irq = 4'b0001;
        idle(); idle(); idle();
        #1 checkOutput("s5_in_trap", 32'(trapReq), 32'h1);
        #2 rstN = 1'b0; irq = 4'b0;
        #1 checkOutput("s5_reset_trap_req", 32'(trapReq), 32'h0);
        checkOutput("s5_reset_redirect", redirectPc, 32'h0);
        for (int i = 0; i < 7; i++) begin
            csrAddrR = addrList[i];
            #1 checkOutput($sformatf("s5_reset_csr_%03h", addrList[i]), csrRdata, 32'h0);
        end
        idle(); idle();
        rstN = 1'b1;
        idle(); idle(); idle();
        #1 checkOutput("s5_after_reset", 32'(trapReq), 32'h0);
        peek("s5_mstatus_after", A_MSTATUS, 32'h0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning CSR data and PC width.
REQ-002 SHALL have parameter NUM_IRQ, default 4, legal range 1..16, meaning external interrupt channel count.
REQ-003 SHALL have parameter IRQ_EDGE, default all-zero NUM_IRQ-bit mask, where a set bit makes that channel edge-triggered and a clear bit makes it level-triggered.
REQ-004 clk_i  in  1  clock; one clock domain; reset is asynchronous and active-low (rst_ni).
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 irq_i  in  NUM_IRQ  asynchronous external interrupt lines.
REQ-007 csr_addr_r_i  in  12  CSR read address.
REQ-008 csr_rdata_o  out  DATA_WIDTH  CSR read data, combinational from csr_addr_r_i.
REQ-009 csr_we_i  in  1  CSR write enable.
REQ-010 csr_addr_w_i  in  12  CSR write address.
REQ-011 csr_wdata_i  in  DATA_WIDTH  CSR write data.
REQ-012 pc_i  in  DATA_WIDTH  PC of the next instruction, saved on trap entry.
REQ-013 mret_i  in  1  MRET executing, one-cycle pulse.
REQ-014 trap_ack_i  in  1  pipeline has taken the redirect.
REQ-015 trap_req_o  out  1  interrupt redirect request.
REQ-016 redirect_pc_o  out  DATA_WIDTH  redirect target; the trap vector while trap_req_o is high, mepc while mret_i is high, otherwise 0.

Function
REQ-017 The CSR map SHALL be 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x344 mip; unmapped reads SHALL return 0 and unmapped writes SHALL be ignored.
REQ-018 Channel i SHALL map to mip/mie bit 16+i; all other mip/mie bits SHALL read 0; mip SHALL be read-only.
REQ-019 Each irq_i bit SHALL pass a 2-flop synchroniser, giving 2 cycles from irq_i to mip.
REQ-020 A level channel's pending bit SHALL equal its synchronised level.
REQ-021 An edge channel's pending bit SHALL set on a synchronised rising edge and clear only when a trap is taken for that channel; a set on the same cycle as the clear SHALL win.
REQ-022 The FSM SHALL have states IDLE and TRAP.
REQ-023 In IDLE, mstatus.MIE(bit 3)=1, no mret_i, and any (pending & mie) bit set SHALL select the lowest-index channel k and, in that cycle: mepc<=pc_i, mcause<={1'b1, k+16}, MPIE(bit 7)<=MIE, MIE<=0, state<=TRAP.
REQ-024 In TRAP, trap_req_o SHALL be 1; state SHALL return to IDLE on the cycle trap_ack_i=1; no new trap SHALL be taken in TRAP.
REQ-025 Trap vector SHALL be {mtvec[DW-1:2],2'b00} when mtvec[1:0]=0, and that base + 4*(k+16) when mtvec[1:0]=1; mtvec[1:0] values 2 and 3 SHALL behave as 0.
REQ-026 mret_i in IDLE SHALL do MIE<=MPIE and MPIE<=1, and redirect_pc_o SHALL equal mepc in that cycle.
REQ-027 mret_i and a takeable interrupt in the same cycle: mret SHALL win and the interrupt SHALL be evaluated next cycle.
REQ-028 A CSR write coinciding with trap entry: the hardware updates to mstatus/mepc/mcause SHALL win; writes to other CSRs SHALL complete.
REQ-029 Written mepc SHALL have bits [1:0] forced to 0; mstatus SHALL store only bits 3 and 7.
REQ-030 mret_i in TRAP SHALL be ignored.

Reset
REQ-031 On rst_ni low, all CSRs, synchronisers and pending bits SHALL clear to 0, state SHALL go to IDLE, and trap_req_o and redirect_pc_o SHALL be 0, immediately and asynchronously.
REQ-032 Reset in TRAP SHALL abandon the trap without requiring trap_ack_i.

Structure
REQ-033 CSR address constants, mstatus bit indices and the FSM state enum SHALL live in a shared csr_pkg.
REQ-034 Per-channel synchroniser and pending logic SHALL be one sub-module, irq_pending, instantiated NUM_IRQ times.

Verification
REQ-035 Scenario: mie=0x10000, MIE=1, irq_i[0] high at cycle 0 -> trap_req_o at cycle 3, mcause=0x80000010, mepc=pc_i, MIE=0, MPIE=1.
REQ-036 Scenario: mtvec=0x1001, channels 1 and 3 pending and enabled -> channel 1 taken, redirect_pc_o=0x1044.
REQ-037 Scenario: mret_i in the same cycle as a takeable interrupt -> redirect_pc_o=mepc, MIE=1, trap taken the following cycle.
REQ-038 Scenario: IRQ_EDGE[2]=1, single-cycle pulse on irq_i[2] with MIE=0 -> mip bit 18 stays 1; setting MIE=1 -> trap taken, bit cleared.
REQ-039 Scenario: rst_ni low while in TRAP with trap_ack_i=0 -> trap_req_o=0 immediately, all CSRs read 0.
